// File: rtl/seq_det_ctrl.sv
// Word-level sequencer for a serial 10110 detector: serializes each accepted word
// MSB-first, owns the detector reset, and reports the per-word match count.
module seq_det_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             det_rst,
   output logic             det_data,
   input  logic             det_hit,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat,
   output logic             busy
);

   localparam int BW = $clog2(WIDTH + 1);
   localparam logic [BW-1:0]    BIT_LOAD = BW'(WIDTH);
   localparam logic [BW-1:0]    BIT_LAST = BW'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {IDLE, SHIFT, DRAIN, REPORT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [BW-1:0]    bit_cnt;
   logic             sample_hit;

   // The first SHIFT cycle still reflects the detector's reset state, so it is skipped.
   assign sample_hit = det_hit && (((state == SHIFT) && (bit_cnt != BIT_LOAD)) || (state == DRAIN));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         shreg     <= '0;
         bit_cnt   <= '0;
         in_ready  <= 1'b1;
         det_rst   <= 1'b1;
         det_data  <= 1'b0;
         out_valid <= 1'b0;
         out_count <= '0;
         out_sat   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (sample_hit) begin
            if (out_count == CNT_MAX) out_sat <= 1'b1;
            else                      out_count <= out_count + 1'b1;
         end
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg     <= in_data << 1;
                  det_data  <= in_data[WIDTH-1];
                  det_rst   <= 1'b0;
                  bit_cnt   <= BIT_LOAD;
                  out_count <= '0;
                  out_sat   <= 1'b0;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= SHIFT;
               end
            end
            SHIFT: begin
               bit_cnt <= bit_cnt - 1'b1;
               if (bit_cnt == BIT_LAST) begin
                  det_data <= 1'b0;
                  state    <= DRAIN;
               end else begin
                  det_data <= shreg[WIDTH-1];
                  shreg    <= shreg << 1;
               end
            end
            DRAIN: begin
               det_rst   <= 1'b1;
               out_valid <= 1'b1;
               state     <= REPORT;
            end
            REPORT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
